// File: rtl/nand_exerciser.sv
// Drives all four input combinations into an external 2-input NAND, checks its output and reports errors.
// Optional build macro NAND_EXERCISER_STOP_ON_FAIL_EN ends a run at the first mismatch.
module nand_exerciser #(
  parameter int SETTLE = 2,
  parameter int LOOPS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       drv_a,
  output logic       drv_b,
  input  logic       dut_x,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] C_LOOP_LAST   = 4'(LOOPS - 1);

  state_t     r_state;
  logic [1:0] r_vec;
  logic [3:0] r_settle_cnt;
  logic [3:0] r_loop;
  logic       r_drv_a;
  logic       r_drv_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err;
  logic [3:0] r_fail;

  logic       w_expect;
  logic       w_mismatch;
  logic [3:0] w_err_next;
  logic [3:0] w_fail_next;
  logic [1:0] w_vec_next;
  logic       w_last;
  logic       w_stop;

  assign w_expect    = ~(r_drv_a & r_drv_b);
  // Case inequality so that an X or Z from the gate under test is an error.
  assign w_mismatch  = (dut_x !== w_expect);
  assign w_err_next  = (w_mismatch && (r_err != 4'hF)) ? r_err + 4'd1 : r_err;
  assign w_fail_next = r_fail | (w_mismatch ? (4'b0001 << r_vec) : 4'b0000);
  assign w_vec_next  = r_vec + 2'd1;
  assign w_last      = (r_vec == 2'd3) && (r_loop == C_LOOP_LAST);

`ifdef NAND_EXERCISER_STOP_ON_FAIL_EN
  assign w_stop = w_last | w_mismatch;
`else
  assign w_stop = w_last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vec        <= 2'd0;
      r_settle_cnt <= 4'd0;
      r_loop       <= 4'd0;
      r_drv_a      <= 1'b0;
      r_drv_b      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= 4'd0;
      r_fail       <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_drv_a <= 1'b0;
          r_drv_b <= 1'b0;
          if (start) begin
            r_state      <= S_SETTLE;
            r_vec        <= 2'd0;
            r_loop       <= 4'd0;
            r_settle_cnt <= 4'd0;
            r_busy       <= 1'b1;
            r_err        <= 4'd0;
            r_fail       <= 4'd0;
            r_pass       <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == C_SETTLE_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_err  <= w_err_next;
          r_fail <= w_fail_next;
          if (w_stop) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 4'd0);
            r_drv_a <= 1'b0;
            r_drv_b <= 1'b0;
            r_vec   <= 2'd0;
            r_loop  <= 4'd0;
          end else begin
            r_state      <= S_SETTLE;
            r_vec        <= w_vec_next;
            r_drv_a      <= w_vec_next[1];
            r_drv_b      <= w_vec_next[0];
            r_settle_cnt <= 4'd0;
            if (r_vec == 2'd3) begin
              r_loop <= r_loop + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign drv_a    = r_drv_a;
  assign drv_b    = r_drv_b;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_vec = r_fail;

endmodule

// File: doc/nand_exerciser.md
NAND_EXERCISER -- requirements
Module: nand_exerciser

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning cycles (1..15) that a vector is held before its output is sampled.
REQ-002 SHALL have parameter LOOPS, default 1, meaning full passes (1..15) through the four input vectors.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-006 SHALL have port drv_a  output  1  drives NAND input A.
REQ-007 SHALL have port drv_b  output  1  drives NAND input B.
REQ-008 SHALL have port dut_x  input  1  NAND output X under test.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-011 SHALL have port pass  output  1  result of last run; valid from done until next accepted start.
REQ-012 SHALL have port err_cnt  output  4  mismatch count, saturating at 15.
REQ-013 SHALL have port fail_vec  output  4  bit i set if vector i ({drv_a,drv_b}=i) mismatched in any loop.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 SHALL, in IDLE with start=1, move to SETTLE at next edge; set vector to 0, loop count to 0, busy=1; clear err_cnt, fail_vec and pass.
REQ-016 SHALL hold {drv_a,drv_b} at the vector index for the whole SETTLE and SAMPLE time of that vector.
REQ-017 SHALL remain in SETTLE for exactly SETTLE cycles, then enter SAMPLE for exactly one cycle.
REQ-018 SHALL, in SAMPLE, compare dut_x against expected ~(drv_a & drv_b) using 4-state equality; X or Z on dut_x counts as a mismatch.
REQ-019 SHALL, on mismatch, increment err_cnt (saturating at 15) and set fail_vec[vector].
REQ-020 SHALL, leaving SAMPLE, advance vector 0->1->2->3; on 3, wrap to 0 and increment the loop count; after vector 3 of loop LOOPS-1, enter DONE, otherwise enter SETTLE.
REQ-021 SHALL take 4*LOOPS*(SETTLE+1) edges from the start-accept edge to DONE entry (12 with defaults).
REQ-022 SHALL, in DONE, assert done=1 for exactly one cycle, set busy=0, set pass=1 iff err_cnt==0, drive drv_a=drv_b=0, then return to IDLE.
REQ-023 SHALL ignore start in SETTLE, SAMPLE and DONE; no restart, no counter clear.
REQ-024 SHALL hold err_cnt, fail_vec and pass unchanged in IDLE until the next accepted start.
REQ-025 SHALL drive drv_a=drv_b=0 in IDLE.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-run, immediately force state IDLE, drv_a=0, drv_b=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, vector=0, loop count=0.
REQ-027 SHALL accept no start while rst=1; the first start is accepted at the first edge after rst deasserts.

Configuration
REQ-028 SHALL provide macro NAND_EXERCISER_STOP_ON_FAIL_EN; when defined, the first mismatch makes SAMPLE go directly to DONE (pass=0, err_cnt=1, remaining vectors skipped).
REQ-029 SHALL, without NAND_EXERCISER_STOP_ON_FAIL_EN, always run all 4*LOOPS vectors regardless of mismatches.

Verification
REQ-030 SHALL cover: correct NAND on dut_x, defaults, start pulse -> done at edge 12, pass=1, err_cnt=0, fail_vec=0000.
REQ-031 SHALL cover: dut_x stuck at 1 -> err_cnt=1, fail_vec=1000, pass=0; with LOOPS=3 -> err_cnt=3, fail_vec=1000.
REQ-032 SHALL cover: dut_x stuck at 0 -> err_cnt=3, fail_vec=0111; with NAND_EXERCISER_STOP_ON_FAIL_EN -> err_cnt=1, fail_vec=0001, done at edge 3.
REQ-033 SHALL cover: dut_x=X on vector 2 only -> err_cnt=1, fail_vec=0100, pass=0.
REQ-034 SHALL cover: rst pulse at edge 5 of a run -> all outputs zero immediately; a new start then completes normally with done 12 edges later.
REQ-035 SHALL cover: start re-asserted at edges 3 and 11 of a run -> ignored; single done at edge 12, counts unaffected.
